// File: rtl/mctrl_pkg.sv
// Shared definitions for the multi-cycle ARM control FSM.
//   state_t : 4-bit binary state encoding (FETCH=0 .. TRAP=10)
//   SRCB_*  : ALUSrcB select codes
//   RES_*   : ResultSrc select codes
//   OP_*    : instruction Op field codes
//   ctrl_t  : control word produced by mctrl_outdec
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mctrl_outdec.sv
// Combinational state -> control-word decoder.
//   state_i     : current FSM state
//   mem_ready_i : memory handshake (only FETCH strobes depend on it)
//   ctrl_c      : datapath selects and unconditioned strobes
module mctrl_outdec
  import mctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRCB_FOUR;
        ctrl_c.result_src = RES_ALU;
        ctrl_c.ir_write   = mem_ready_i;
        ctrl_c.next_pc    = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRCB_FOUR;
        ctrl_c.result_src = RES_ALU;
      end
      S_MEMADR: begin
        ctrl_c.alu_src_b  = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_c.adr_src    = 1'b1;
        ctrl_c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl_c.result_src = RES_DATA;
        ctrl_c.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c.adr_src    = 1'b1;
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.mem_w      = 1'b1;
      end
      S_EXECR: begin
        ctrl_c.alu_src_b  = SRCB_REG;
        ctrl_c.alu_op     = 1'b1;
      end
      S_EXECI: begin
        ctrl_c.alu_src_b  = SRCB_IMM;
        ctrl_c.alu_op     = 1'b1;
      end
      S_ALUWB: begin
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_b  = SRCB_IMM;
        ctrl_c.result_src = RES_ALU;
        ctrl_c.branch     = 1'b1;
      end
      // TRAP and illegal encodings drive an all-zero control word
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencing FSM of the multi-cycle ARM core.
// Optional feature macro: MCTRL_UNDEF_TRAP_EN (Op=11 traps instead of NOP).
// Ports:
//   clk, reset (async, active-low)
//   Op[1:0], Funct[5:0] : instruction fields, sampled in DECODE/MEMADR
//   mem_ready           : memory access completes this cycle
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp : datapath control
//   NextPC, RegW, MemW, Branch : unconditioned strobes
//   instret             : retired-instruction counter (wraps)
//   undef               : sticky undefined-opcode flag
module multicycle_ctrl_fsm
  import mctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             NextPC,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic [CNT_W-1:0] instret,
  output logic             undef
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             undef_q, undef_d;
  ctrl_t            ctrl;

  // Only I (Funct[5]) and L/S (Funct[0]) steer sequencing
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // Next-state and retirement logic
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    undef_d = undef_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM: state_d = S_MEMADR;
          OP_DP:  state_d = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:  state_d = S_BRANCH;
          default: begin
`ifdef MCTRL_UNDEF_TRAP_EN
            state_d = S_TRAP;
            undef_d = 1'b1;
`else
            // Undefined opcode retires as a NOP
            state_d = S_FETCH;
            retire  = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`ifdef MCTRL_UNDEF_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      // Illegal encodings recover to FETCH without retiring
      default:  state_d = S_FETCH;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      undef_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      undef_q   <= undef_d;
    end
  end

  mctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_c      (ctrl)
  );

  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ALUOp     = ctrl.alu_op;
  assign NextPC    = ctrl.next_pc;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;
  assign instret   = instret_q;

`ifdef MCTRL_UNDEF_TRAP_EN
  assign undef = undef_q;
`else
  // Flag is meaningless without the trap; keep the flop's value unobserved
  logic unused_undef;
  assign unused_undef = undef_q;
  assign undef = 1'b0;
`endif

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main sequencing FSM of the multi-cycle ARM core.
- Decodes Op/Funct from the instruction register and walks each instruction through fetch, decode, execute, memory and writeback steps.
- Drives datapath mux selects plus the unconditioned RegW/MemW/NextPC/Branch strobes consumed by the conditional-logic stage.
- Supports a variable-latency memory through a ready handshake and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- Op  in  2  instruction bits [27:26]
- Funct  in  6  instruction bits [25:20]; Funct[5]=I, Funct[0]=L/S
- mem_ready  in  1  memory access completes this cycle
- IRWrite  out  1  load instruction register
- AdrSrc  out  1  0=PC, 1=ALU result register
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=reg B, 01=ExtImm, 10=const 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUOp  out  1  1=decode Funct for ALU op, 0=add
- NextPC  out  1  unconditional PC update
- RegW  out  1  register write request (pre-condition)
- MemW  out  1  memory write request (pre-condition)
- Branch  out  1  branch request (pre-condition)
- instret  out  CNT_W  retired-instruction count
- undef  out  1  sticky undefined-opcode flag (0 when feature absent)

Behaviour:
- State register is 4-bit binary: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, TRAP=10.
- Reset (async, reset=0): state=FETCH, instret=0, undef=0. All outputs are a Moore function of state except as noted, so FETCH values apply during reset.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - IRWrite=NextPC=mem_ready (Mealy).
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10. Next state:
  - Op=01 -> MEMADR
  - Op=00 & Funct[5]=0 -> EXECR
  - Op=00 & Funct[5]=1 -> EXECI
  - Op=10 -> BRANCH
  - Op=11 -> see Optional Feature
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Funct[0]=1 -> MEMRD, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: ResultSrc=01, RegW=1. -> FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1 held every cycle. -> FETCH on mem_ready=1.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1. -> ALUWB.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. -> ALUWB.
- ALUWB: ResultSrc=00, RegW=1. -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1. -> FETCH.
- Unlisted outputs are 0 in every state.
- instret increments by 1 on each transition into FETCH from MEMWB, MEMWR (when mem_ready=1), ALUWB or BRANCH. It wraps at all-ones to 0.
- Op and Funct are sampled only in DECODE and MEMADR; they are don't-care elsewhere.
- Illegal state encodings (11-15) -> FETCH on the next edge, with no instret increment.
- Reset asserted mid-instruction aborts the instruction immediately; no strobe remains asserted after reset.

Optional Feature:
- Macro: MCTRL_UNDEF_TRAP_EN.
- Defined:
  - DECODE with Op=11 -> TRAP.
  - TRAP asserts no strobes and is absorbing until reset.
  - undef is set on entry to TRAP and is sticky until reset.
- Undefined: DECODE with Op=11 -> FETCH as a NOP. instret increments, undef is tied 0, and the TRAP encoding is unreachable (treated as illegal).

Decomposition:
- Shared package mctrl_pkg holds:
  - state enum encodings
  - ALUSrcB codes (SRCB_REG, SRCB_IMM, SRCB_FOUR)
  - ResultSrc codes (RES_ALUOUT, RES_DATA, RES_ALU)
  - Op codes (OP_DP=00, OP_MEM=01, OP_BR=10)
- One sub-module, mctrl_outdec: purely combinational state -> control-word decoder. The top keeps the state register, next-state logic and counters.

Test Plan:
- ADD reg (Op=00, Funct=000100), mem_ready=1 -> states 0,1,6,8,0. RegW=1 only in ALUWB; instret 0->1.
- LDR (Op=01, Funct=011001), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with ResultSrc=01, RegW=1.
- STR (Op=01, Funct=011000), mem_ready low 2 cycles -> MemW=1 for 3 consecutive cycles; instret increments once.
- B (Op=10) -> BRANCH with Branch=1, ALUSrcB=01, ResultSrc=10; next state FETCH.
- Fetch stall (mem_ready=0 for 5 cycles) -> IRWrite=NextPC=0 throughout, state=FETCH. reset=0 in EXECI -> immediate FETCH, instret=0.
- Op=11 -> with MCTRL_UNDEF_TRAP_EN: TRAP, undef=1 persists 10 cycles. Without: returns to FETCH, undef=0.
